// File: rtl/arbiter_8way.sv
// ---------------------------------------------------------------------------
// arbiter_8way
//   Round-robin arbiter for an 8-way downstream selector. It holds one grant
//   at a time and inserts exactly one idle cycle between grants. After a
//   grant is released, the requester following the released owner gets the
//   highest priority.
//
//   Parameters
//     TIMEOUT  maximum number of cycles a grant may be held (2..255). It is
//              used only when ARB_TIMEOUT_EN is defined.
//
//   Optional feature
//     ARB_TIMEOUT_EN  When defined, builds an 8-bit hold counter. The counter
//                     force-releases a grant after TIMEOUT cycles and pulses
//                     timeout for one cycle. When undefined, no counter is
//                     built and timeout is tied to 0.
//
//   Ports
//     clk      in   1  rising-edge clock
//     reset    in   1  synchronous active-high reset
//     req      in   8  request lines, one per selector input
//     done     in   1  current owner releases its grant this cycle
//     sel      out  3  registered index of the granted requester
//     gnt      out  8  registered one-hot grant (0 when not valid)
//     valid    out  1  registered; high while a grant is held
//     timeout  out  1  registered one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module arbiter_8way #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       valid,
  output logic       timeout
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("arbiter_8way: TIMEOUT must be in 2..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_d;
  logic [7:0] gnt_d;
  logic       valid_d;
  logic [2:0] pick;
  logic       rel_evt;

  // Rotate the request vector so that ptr sits at bit 0. Then take the lowest
  // set bit and add ptr back, which gives a circular scan ptr, ptr+1, ...
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [2:0]  off;
    dbl = {r, r} >> p;
    rot = dbl[7:0];
    off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
    return p + off;
  endfunction

  assign pick    = rr_pick(req, ptr_q);
  // A withdrawn request and an explicit done are the same release event.
  assign rel_evt = done | ~req[sel];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       tmo_q, tmo_d;
  logic       expire;

  assign expire  = (state_q == GRANT) && (cnt_q == HOLD_LAST);
  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel;
    gnt_d   = gnt;
    valid_d = valid;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        gnt_d   = 8'h00;
        if (|req) begin
          state_d = GRANT;
          sel_d   = pick;
          gnt_d   = 8'h01 << pick;
          valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      GRANT: begin
`ifdef ARB_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
        if (rel_evt || expire) begin
          // A real release in the expiry cycle takes priority, so no pulse.
          tmo_d = expire && !rel_evt;
`else
        if (rel_evt) begin
`endif
          state_d = IDLE;
          valid_d = 1'b0;
          gnt_d   = 8'h00;
          ptr_d   = sel + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / state register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      sel     <= 3'd0;
      gnt     <= 8'h00;
      valid   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel     <= sel_d;
      gnt     <= gnt_d;
      valid   <= valid_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_arbiter_8way.sv
// ---------------------------------------------------------------------------
// tb_arbiter_8way
//   Scoreboard bench for arbiter_8way. The directed stimulus pushes the
//   expected grant index of every new grant into a queue. A monitor pops one
//   entry on each rising edge of valid and also checks that gnt always
//   matches valid/sel. Directed checks cover reset, latency, stability,
//   the idle gap and the hold limit. The hold limit runs with or without
//   ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_arbiter_8way;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  logic [2:0] sb_q[$];
  logic       mon_en = 1'b0;
  logic       valid_prev = 1'b0;

  arbiter_8way #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .sel(sel), .gnt(gnt), .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("gnt_onehot", gnt, valid ? (32'h1 << sel) : 32'h0);
      if (valid && !valid_prev) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_grant", {29'd0, sel}, 32'hFFFF_FFFF);
        end else begin
          chk("grant_sel", {29'd0, sel}, {29'd0, sb_q.pop_front()});
        end
      end
      valid_prev <= valid;
    end
  end

  initial begin
    reset = 1'b1; req = 8'h00; done = 1'b0;
    step(2);
    chk("rst_valid", valid, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_sel", sel, 0);
    chk("rst_timeout", timeout, 0);
    mon_en = 1'b1;

    // Single requester: one-cycle latency, stable while held, withdraw releases.
    reset = 1'b0; req = 8'h04; sb_q.push_back(3'd2);
    step(1);
    chk("lat_valid", valid, 1);
    chk("lat_gnt", gnt, 8'h04);
    req = 8'h0C;
    step(2);
    chk("hold_sel", sel, 2);
    chk("hold_valid", valid, 1);
    req = 8'h00;
    step(1);
    chk("withdraw_valid", valid, 0);
    chk("idle_sel_hold", sel, 2);
    done = 1'b1;
    step(1);
    chk("done_in_idle", valid, 0);
    done = 1'b0;

    // Fairness: all requesting, done held, so each grant lasts one cycle.
    reset = 1'b1; step(1); reset = 1'b0;
    for (int i = 0; i < 8; i++) sb_q.push_back(3'(i));
    sb_q.push_back(3'd0);
    req = 8'hFF; done = 1'b1;
    step(17);
    chk("fair_last_valid", valid, 1);
    chk("fair_last_sel", sel, 0);
    req = 8'h00;
    step(2);
    done = 1'b0;
    chk("fair_sb_empty", sb_q.size(), 0);

    // Pointer wrap: ptr=1, so grant 7, then wrap to 0, then back to 7.
    sb_q.push_back(3'd7); sb_q.push_back(3'd0); sb_q.push_back(3'd7);
    req = 8'h80;
    step(1);
    chk("wrap_g7", sel, 7);
    req = 8'h81; done = 1'b1;
    step(1);
    chk("wrap_idle", valid, 0);
    step(1);
    chk("wrap_g0", sel, 0);
    step(2);
    chk("wrap_g7b", sel, 7);
    req = 8'h00;
    step(1);
    done = 1'b0;
    chk("wrap_sb_empty", sb_q.size(), 0);

    // Withdraw at sel=3 moves ptr to 4.
    sb_q.push_back(3'd3); sb_q.push_back(3'd4);
    req = 8'h08;
    step(3);
    chk("w3_sel", sel, 3);
    req = 8'h00;
    step(1);
    chk("w3_release", valid, 0);
    req = 8'h18;
    step(1);
    chk("w3_next", sel, 4);
    req = 8'h00;
    step(1);

    // Reset mid-grant.
    sb_q.push_back(3'd5); sb_q.push_back(3'd4);
    req = 8'h20;
    step(1);
    chk("mid_sel5", sel, 5);
    reset = 1'b1;
    step(1);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_sel", sel, 0);
    reset = 1'b0; req = 8'h30;
    step(1);
    chk("post_rst_sel", sel, 4);
    req = 8'h00;
    step(1);

    // Hold limit: ptr=5, req=01 held, done low for 20 cycles.
    sb_q.push_back(3'd0);
`ifdef ARB_TIMEOUT_EN
    sb_q.push_back(3'd0);
`endif
    req = 8'h01;
    for (int k = 1; k <= 20; k++) begin
      step(1);
`ifdef ARB_TIMEOUT_EN
      chk("hold_valid_k", valid, (k == 17) ? 0 : 1);
      chk("hold_tmo_k", timeout, (k == 17) ? 1 : 0);
`else
      chk("hold_valid_k", valid, 1);
      chk("hold_tmo_k", timeout, 0);
`endif
    end
`ifdef ARB_TIMEOUT_EN
    // The regrant started at edge 18, so its 16th cycle follows edge 33.
    step(13);
    chk("pre_expiry_valid", valid, 1);
`endif
    done = 1'b1;
    step(1);
    chk("done_release_valid", valid, 0);
    chk("done_release_tmo", timeout, 0);
    done = 1'b0; req = 8'h00;
    step(3);
    chk("final_sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
